// File: rtl/tff_timer_arbiter.sv
// Round-robin arbiter sharing one T-flip-flop up-counter among NREQ duration timers.
// Optional macro TFF_TIMER_PAUSE_EN adds a 'pause' input that freezes counting during RUN.
module tff_timer_arbiter #(
   parameter int NREQ = 4,
   parameter int CW   = 8,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               clr,
`ifdef TFF_TIMER_PAUSE_EN
   input  logic               pause,
`endif
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*CW-1:0] dur,
   output logic [NREQ-1:0]    grant,
   output logic               busy,
   output logic [CW-1:0]      count,
   output logic               done,
   output logic               abort,
   output logic [IDW-1:0]     owner
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic [IDW-1:0] rr_q, rr_d;
   logic [CW-1:0]  dur_q, dur_d;
   logic [CW-1:0]  count_q, count_d;
   logic           abort_q, abort_d;

   logic           pause_i;
   logic           req_own;
   logic [CW-1:0]  dur_own;
   logic           last;
   logic           run_en;
   logic           clr_cnt;
   logic [IDW-1:0] winner;
   logic           found;

`ifdef TFF_TIMER_PAUSE_EN
   assign pause_i = pause;
`else
   assign pause_i = 1'b0;
`endif

   assign req_own = req[owner_q];
   assign dur_own = dur[int'(owner_q)*CW +: CW];
   assign last    = (count_q == dur_q - CW'(1));

   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin
      int idx;
      idx    = 0;
      winner = rr_q;
      found  = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = (int'(rr_q) + i) % NREQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      dur_d   = dur_q;
      abort_d = 1'b0;
      run_en  = 1'b0;
      clr_cnt = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = LOAD;
               owner_d = winner;
               rr_d    = winner;
            end
         end
         LOAD: begin
            clr_cnt = 1'b1;
            dur_d   = dur_own;
            if (!req_own) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else if (dur_own == '0) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Abort wins over pause and completion; the final count is never advanced.
            if (!req_own) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else if (pause_i) begin
               state_d = RUN;
            end else if (last) begin
               state_d = DONE;
            end else begin
               run_en = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Synchronous toggle chain: bit i toggles when all lower bits are 1.
   always_comb begin
      logic carry;
      carry   = 1'b1;
      count_d = count_q;
      for (int i = 0; i < CW; i++) begin
         count_d[i] = clr_cnt ? 1'b0 : (count_q[i] ^ (run_en & carry));
         carry      = carry & count_q[i];
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= IDW'(NREQ - 1);
         dur_q   <= '0;
         count_q <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         dur_q   <= dur_d;
         count_q <= count_d;
         abort_q <= abort_d;
      end
   end

   assign busy  = (state_q != IDLE);
   assign grant = busy ? (NREQ'(1) << owner_q) : '0;
   assign done  = (state_q == DONE);
   assign abort = abort_q;
   assign count = count_q;
   assign owner = owner_q;

endmodule

// File: tb/tb_tff_timer_arbiter.sv
// Bench for tff_timer_arbiter: directed scenarios then random transactions checked
// against a transaction-level timeline model (winner, grant window, count ramp, done/abort).
module tb_tff_timer_arbiter;

   logic        clk;
   logic        clr;
   logic        pause;
   logic [3:0]  req;
   logic [31:0] dur;
   logic [3:0]  grant;
   logic        busy;
   logic [7:0]  count;
   logic        done;
   logic        abort;
   logic [1:0]  owner;

   int checks;
   int errors;
   int rrPtr;
   int lastCount;
   int lastOwner;

   tff_timer_arbiter #(.NREQ(4), .CW(8)) dut (
      .clk   (clk),
      .clr   (clr),
`ifdef TFF_TIMER_PAUSE_EN
      .pause (pause),
`endif
      .req   (req),
      .dur   (dur),
      .grant (grant),
      .busy  (busy),
      .count (count),
      .done  (done),
      .abort (abort),
      .owner (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Round-robin reference: first requester after the previous winner, wrapping.
   function automatic int pickWinner(input logic [3:0] r);
      for (int i = 1; i <= 4; i++) begin
         if (r[(rrPtr + i) % 4]) return (rrPtr + i) % 4;
      end
      return -1;
   endfunction

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_grant"}, 32'(grant), 0);
      checkOutput({tag, "_busy"},  32'(busy),  0);
      checkOutput({tag, "_done"},  32'(done),  0);
      checkOutput({tag, "_abort"}, 32'(abort), 0);
      checkOutput({tag, "_count"}, 32'(count), lastCount);
      checkOutput({tag, "_owner"}, 32'(owner), lastOwner);
   endtask

   // One transaction starting from IDLE; abortAt = RUN cycle whose count value sees req drop (-1 = none).
   task automatic applyStimulus(input logic [3:0] reqPat, input logic [31:0] durs, input int abortAt);
      int w;
      int d;
      logic [3:0] r;
      req = reqPat;
      dur = durs;
      w = pickWinner(reqPat);
      if (w < 0) begin
         step();
         checkIdle("noreq");
         return;
      end
      rrPtr = w;
      d = int'(durs[w*8 +: 8]);
      step();
      checkOutput("load_grant", 32'(grant), 32'(1) << w);
      checkOutput("load_busy",  32'(busy),  1);
      checkOutput("load_owner", 32'(owner), w);
      checkOutput("load_done",  32'(done),  0);
      for (int j = 0; j < d; j++) begin
         step();
         checkOutput("run_count", 32'(count), j);
         checkOutput("run_grant", 32'(grant), 32'(1) << w);
         checkOutput("run_done",  32'(done),  0);
         checkOutput("run_abort", 32'(abort), 0);
         dur = $urandom;
         r = 4'($urandom) | (4'b1 << w);
         if (j == abortAt) r[w] = 1'b0;
         req = r;
         if (j == abortAt) begin
            step();
            checkOutput("abort_pulse", 32'(abort), 1);
            checkOutput("abort_grant", 32'(grant), 0);
            checkOutput("abort_busy",  32'(busy),  0);
            checkOutput("abort_done",  32'(done),  0);
            checkOutput("abort_count", 32'(count), j);
            lastCount = j;
            lastOwner = w;
            return;
         end
      end
      step();
      lastCount = (d == 0) ? 0 : d - 1;
      lastOwner = w;
      checkOutput("done_pulse", 32'(done),  1);
      checkOutput("done_grant", 32'(grant), 32'(1) << w);
      checkOutput("done_count", 32'(count), lastCount);
      checkOutput("done_abort", 32'(abort), 0);
      req = 4'($urandom);
      step();
      checkIdle("post_done");
   endtask

   initial begin
      logic [3:0]  rp;
      logic [31:0] dv;
      int ab;
      checks    = 0;
      errors    = 0;
      rrPtr     = 3;
      lastCount = 0;
      lastOwner = 0;
      clr   = 1'b0;
      pause = 1'b0;
      req   = '0;
      dur   = '0;
      #11;
      checkIdle("reset");
      #1 clr = 1'b1;
      step();
      checkIdle("reset_rel");

      // Asynchronous reset while counting: outputs clear before the next edge.
      req = 4'b0001;
      dur = 32'd9;
      step();
      checkOutput("rst_load_grant", 32'(grant), 1);
      for (int j = 0; j <= 5; j++) begin
         step();
         checkOutput("rst_run_count", 32'(count), j);
      end
      #2 clr = 1'b0;
      #1;
      checkOutput("rst_async_grant", 32'(grant), 0);
      checkOutput("rst_async_busy",  32'(busy),  0);
      checkOutput("rst_async_count", 32'(count), 0);
      checkOutput("rst_async_done",  32'(done),  0);
      checkOutput("rst_async_owner", 32'(owner), 0);
      req = '0;
      #2 clr = 1'b1;
      rrPtr = 3;
      lastCount = 0;
      lastOwner = 0;
      step();
      checkIdle("rst_mid_idle");

      applyStimulus(4'b0001, 32'h0000_0003, -1);
      for (int k = 0; k < 5; k++) applyStimulus(4'b1111, 32'h0101_0101, -1);
      applyStimulus(4'b0100, 32'h0000_0000, -1);
      applyStimulus(4'b0010, 32'h0000_0A00, 4);
      applyStimulus(4'b0000, 32'h0505_0505, -1);

      for (int k = 0; k < 40; k++) begin
         rp = 4'($urandom);
         dv = '0;
         for (int b = 0; b < 4; b++) dv[b*8 +: 8] = 8'($urandom_range(0, 6));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
         applyStimulus(rp, dv, ab);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
